// File: rtl/swap_pipe.sv
// rtl/swap_pipe.sv - dual-channel register pipeline with entry-time swap and saturating swap counter
// Stage 0 decides pass/swap; later stages only shift, so data is never re-swapped in flight.
module swap_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] swap_cnt_o
);

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_SWAP  = 2'b01,
      MODE_HOLD  = 2'b10,
      MODE_CLEAR = 2'b11
   } mode_t;

   logic [WIDTH-1:0] a_q [DEPTH];
   logic [WIDTH-1:0] b_q [DEPTH];
   logic [DEPTH-1:0] v_q;
   logic [CNT_W-1:0] swap_cnt_q;
   mode_t            mode;

   assign mode = mode_t'(mode_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
         v_q        <= '0;
         swap_cnt_q <= '0;
      end else begin
         case (mode)
            MODE_PASS, MODE_SWAP: begin
               a_q[0] <= (mode == MODE_SWAP) ? b_i : a_i;
               b_q[0] <= (mode == MODE_SWAP) ? a_i : b_i;
               v_q[0] <= valid_i;
               for (int i = 1; i < DEPTH; i++) begin
                  a_q[i] <= a_q[i-1];
                  b_q[i] <= b_q[i-1];
                  v_q[i] <= v_q[i-1];
               end
               // Saturate rather than wrap so a long run never reads as a small count.
               if (mode == MODE_SWAP && valid_i && swap_cnt_q != {CNT_W{1'b1}})
                  swap_cnt_q <= swap_cnt_q + 1'b1;
            end
            MODE_CLEAR: begin
               for (int i = 0; i < DEPTH; i++) begin
                  a_q[i] <= '0;
                  b_q[i] <= '0;
               end
               v_q        <= '0;
               swap_cnt_q <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign a_o        = a_q[DEPTH-1];
   assign b_o        = b_q[DEPTH-1];
   assign valid_o    = v_q[DEPTH-1];
   assign swap_cnt_o = swap_cnt_q;

endmodule

// File: tb/tb_swap_pipe.sv
// tb/tb_swap_pipe.sv - self-checking bench for swap_pipe (DEPTH=2/CNT_W=8 and DEPTH=1/CNT_W=2)
// Directed vector table, hand sequences for saturation and async reset, then random traffic vs a queue model.
module tb_swap_pipe;

   logic       clk = 1'b1;
   logic       rst_n;
   logic [1:0] mode_i;
   logic       valid_i;
   logic [7:0] a_i, b_i;
   logic [7:0] a1, b1, a2, b2;
   logic       v1, v2;
   logic [7:0] cnt1;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   swap_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
      .a_o(a1), .b_o(b1), .valid_o(v1), .swap_cnt_o(cnt1));

   swap_pipe #(.WIDTH(8), .DEPTH(1), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
      .a_o(a2), .b_o(b2), .valid_o(v2), .swap_cnt_o(cnt2));

   // Model: each pipe is a list of accepted entries, newest first; the output is whatever
   // entered DEPTH advancing edges ago.
   typedef struct packed {logic [7:0] a; logic [7:0] b; logic v;} ent_t;
   ent_t q1[$];
   ent_t q2[$];
   int   mc1, mc2;

   typedef struct {
      logic [1:0] mode; logic valid; logic [7:0] a; logic [7:0] b;
      logic [7:0] ea; logic [7:0] eb; logic ev; logic [7:0] ecnt;
   } vec_t;
   vec_t tbl[18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q1 = {};
      q2 = {};
      repeat (2) q1.push_back('0);
      q2.push_back('0);
      mc1 = 0;
      mc2 = 0;
   endtask

   task automatic model_edge(input logic [1:0] m, input logic v, input logic [7:0] a, input logic [7:0] b);
      ent_t e;
      if (m == 2'b00 || m == 2'b01) begin
         e = (m == 2'b01) ? '{a: b, b: a, v: v} : '{a: a, b: b, v: v};
         q1.push_front(e);
         void'(q1.pop_back());
         q2.push_front(e);
         void'(q2.pop_back());
         if (m == 2'b01 && v) begin
            mc1 = (mc1 + 1 > 255) ? 255 : mc1 + 1;
            mc2 = (mc2 + 1 > 3) ? 3 : mc2 + 1;
         end
      end else if (m == 2'b11) begin
         model_reset();
      end
   endtask

   task automatic compare_model(input string tag);
      check({tag, " d1.a"}, a1, q1[$].a);
      check({tag, " d1.b"}, b1, q1[$].b);
      check({tag, " d1.v"}, v1, q1[$].v);
      check({tag, " d1.cnt"}, cnt1, mc1);
      check({tag, " d2.a"}, a2, q2[$].a);
      check({tag, " d2.b"}, b2, q2[$].b);
      check({tag, " d2.v"}, v2, q2[$].v);
      check({tag, " d2.cnt"}, cnt2, mc2);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " d1.a"}, a1, 0);
      check({tag, " d1.b"}, b1, 0);
      check({tag, " d1.v"}, v1, 0);
      check({tag, " d1.cnt"}, cnt1, 0);
      check({tag, " d2.a"}, a2, 0);
      check({tag, " d2.b"}, b2, 0);
      check({tag, " d2.v"}, v2, 0);
      check({tag, " d2.cnt"}, cnt2, 0);
   endtask

   // Inputs are applied away from the edge; outputs are sampled 1 ns after it.
   task automatic step(input logic [1:0] m, input logic v, input logic [7:0] a, input logic [7:0] b);
      mode_i  = m;
      valid_i = v;
      a_i     = a;
      b_i     = b;
      @(posedge clk);
      model_edge(m, v, a, b);
      #1;
   endtask

   initial begin
      tbl[0]  = '{2'b00, 1'b1, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0, 8'd0};
      tbl[1]  = '{2'b00, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b1, 8'd0};
      tbl[2]  = '{2'b01, 1'b1, 8'h01, 8'h02, 8'h00, 8'h00, 1'b0, 8'd1};
      tbl[3]  = '{2'b00, 1'b0, 8'h00, 8'h00, 8'h02, 8'h01, 1'b1, 8'd1};
      tbl[4]  = '{2'b00, 1'b1, 8'h11, 8'h22, 8'h00, 8'h00, 1'b0, 8'd1};
      tbl[5]  = '{2'b10, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'd1};
      tbl[6]  = '{2'b10, 1'b0, 8'hEE, 8'hEE, 8'h00, 8'h00, 1'b0, 8'd1};
      tbl[7]  = '{2'b10, 1'b1, 8'hDD, 8'hDD, 8'h00, 8'h00, 1'b0, 8'd1};
      tbl[8]  = '{2'b00, 1'b1, 8'h33, 8'h44, 8'h11, 8'h22, 1'b1, 8'd1};
      tbl[9]  = '{2'b00, 1'b1, 8'h55, 8'h66, 8'h33, 8'h44, 1'b1, 8'd1};
      tbl[10] = '{2'b01, 1'b0, 8'h77, 8'h88, 8'h55, 8'h66, 1'b1, 8'd1};
      tbl[11] = '{2'b00, 1'b1, 8'h99, 8'hAA, 8'h88, 8'h77, 1'b0, 8'd1};
      tbl[12] = '{2'b00, 1'b1, 8'hBB, 8'hCC, 8'h99, 8'hAA, 1'b1, 8'd1};
      tbl[13] = '{2'b11, 1'b1, 8'hDE, 8'hAD, 8'h00, 8'h00, 1'b0, 8'd0};
      tbl[14] = '{2'b00, 1'b1, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 8'd0};
      tbl[15] = '{2'b01, 1'b1, 8'h56, 8'h78, 8'h12, 8'h34, 1'b1, 8'd1};
      tbl[16] = '{2'b10, 1'b1, 8'h00, 8'h00, 8'h12, 8'h34, 1'b1, 8'd1};
      tbl[17] = '{2'b00, 1'b0, 8'h00, 8'h00, 8'h78, 8'h56, 1'b1, 8'd1};

      rst_n   = 1'b0;
      mode_i  = 2'b00;
      valid_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      model_reset();
      #3;
      check_zero("reset");
      #2;
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].mode, tbl[i].valid, tbl[i].a, tbl[i].b);
         check($sformatf("vec%0d a_o", i), a1, tbl[i].ea);
         check($sformatf("vec%0d b_o", i), b1, tbl[i].eb);
         check($sformatf("vec%0d valid_o", i), v1, tbl[i].ev);
         check($sformatf("vec%0d swap_cnt_o", i), cnt1, tbl[i].ecnt);
         compare_model($sformatf("vec%0d model", i));
      end

      step(2'b11, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) begin
         step(2'b01, 1'b1, 8'(i), 8'(i + 16));
         check($sformatf("sat%0d cnt2", i), cnt2, (i < 2) ? i + 1 : 3);
         check($sformatf("sat%0d cnt1", i), cnt1, i + 1);
      end

      // Async reset pulsed mid-cycle with valid data in flight.
      step(2'b00, 1'b1, 8'hC1, 8'hC2);
      step(2'b00, 1'b1, 8'hC3, 8'hC4);
      #2 rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      #2 rst_n = 1'b1;
      model_reset();
      step(2'b00, 1'b1, 8'h5A, 8'hA5);
      check("post_rst edge1 d1.v", v1, 0);
      check("post_rst edge1 d2.v", v2, 1);
      step(2'b00, 1'b0, 8'h00, 8'h00);
      check("post_rst edge2 d1.v", v1, 1);
      check("post_rst edge2 d1.a", a1, 8'h5A);
      compare_model("post_rst");

      for (int i = 0; i < 400; i++) begin
         int r;
         logic [1:0] m;
         r = $urandom_range(0, 19);
         m = (r < 7) ? 2'b00 : (r < 14) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
         step(m, 1'($urandom), 8'($urandom), 8'($urandom));
         compare_model($sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/swap_pipe.md
SWAP_PIPE -- requirements
Module: swap_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of each channel (legal 1..64).
REQ-002 Parameter DEPTH, default 2, SHALL set the number of register stages per channel (legal 1..16).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the swap counter (legal 1..32).
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 mode_i  input  2  SHALL select the operation: 00 PASS, 01 SWAP, 10 HOLD, 11 CLEAR.
REQ-007 valid_i  input  1  SHALL qualify a_i/b_i as a transfer.
REQ-008 a_i  input  WIDTH  SHALL be channel A input data.
REQ-009 b_i  input  WIDTH  SHALL be channel B input data.
REQ-010 a_o  output  WIDTH  SHALL be channel A data from the last stage.
REQ-011 b_o  output  WIDTH  SHALL be channel B data from the last stage.
REQ-012 valid_o  output  1  SHALL be the valid flag from the last stage.
REQ-013 swap_cnt_o  output  CNT_W  SHALL count accepted SWAP transfers.

Function
REQ-014 Each channel SHALL be a DEPTH-stage register pipeline, with a valid bit per stage, all updated with non-blocking semantics (every stage samples its predecessor's pre-edge value).
REQ-015 PASS: on the edge, stage 0 SHALL load A<=a_i, B<=b_i, V<=valid_i, and stages 1..DEPTH-1 SHALL shift.
REQ-016 SWAP: on the edge, stage 0 SHALL load A<=b_i, B<=a_i, V<=valid_i, and stages 1..DEPTH-1 SHALL shift.
REQ-017 HOLD: all stages, valid bits and swap_cnt_o SHALL retain their values; inputs SHALL be ignored.
REQ-018 CLEAR: all data and valid bits SHALL become 0 on the edge (synchronous); swap_cnt_o SHALL become 0.
REQ-019 Latency SHALL be exactly DEPTH rising edges from input sample to a_o/b_o/valid_o, counting PASS/SWAP edges only (HOLD edges do not advance).
REQ-020 Data SHALL move through the pipeline regardless of valid; valid only tags the data.
REQ-021 Swapping SHALL be decided at entry only; later mode changes SHALL NOT re-swap data already in the pipeline.
REQ-022 swap_cnt_o SHALL increment by 1 on each edge with mode_i=01 and valid_i=1.
REQ-023 swap_cnt_o SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 A SWAP edge with valid_i=0 SHALL still swap the data but SHALL NOT increment swap_cnt_o.
REQ-025 Outputs SHALL be driven directly from last-stage registers, with no combinational path from any input to any output.
REQ-026 DEPTH=1 SHALL behave as a single registered swap/pass stage with latency 1.

Reset
REQ-027 While rst_n=0, all stage data, valid bits and swap_cnt_o SHALL be 0 immediately, independent of clk.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight data.
REQ-029 The first edge after rst_n rises SHALL behave as a normal edge for the current mode_i.
REQ-030 Reset SHALL take priority over every mode, including HOLD.

Verification
REQ-031 Reset/PASS: WIDTH=8, DEPTH=2; rst_n=0 for 5 ns -> all outputs 0; then PASS with a_i=8'hA5, b_i=8'h3C, valid_i=1 -> a_o=A5, b_o=3C, valid_o=1 after 2 edges.
REQ-032 SWAP: a_i=8'h01, b_i=8'h02, valid_i=1, mode 01 for one edge, then PASS -> after 2 edges a_o=02, b_o=01, swap_cnt_o=1.
REQ-033 HOLD mid-flight: load 11/22, HOLD for 3 edges, then PASS -> outputs appear after 2 PASS edges total, and swap_cnt_o is unchanged during HOLD.
REQ-034 CLEAR: pipeline full of valid data, one CLEAR edge -> valid_o=0, a_o=b_o=0, swap_cnt_o=0 on the next edge.
REQ-035 Saturation: CNT_W=2, 5 consecutive valid SWAP edges -> swap_cnt_o sequence 1,2,3,3,3.
REQ-036 Async reset: rst_n pulsed low for 3 ns between clock edges with valid data in flight -> all outputs 0 before the next edge, and valid_o stays 0 until new data has taken DEPTH edges to arrive.
